// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction-fetch sequencer: word width and FSM state encodings.
package fetch_seq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_seq_watchdog.sv
// Wait-cycle counter for an outstanding memory request; expire pulses on the
// counting cycle that brings the count up to TIMEOUT (TIMEOUT = 0 disables it).
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Compare against TIMEOUT-1 so the fault register sets exactly TIMEOUT cycles after the request rose.
  assign o_expire = (TIMEOUT != 0) && i_en && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, fetches over a req/ack memory port,
// presents instructions with valid/stall, takes redirects, halts after last_pc.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] last_pc,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              halted,
  output logic              fault,
  output logic [WORD_W-1:0] retired
);

  fetch_state_t      r_state, w_state_next;
  logic [WORD_W-1:0] r_pc, w_pc_next;
  logic              r_mem_req, w_mem_req_next;
  logic [WORD_W-1:0] r_mem_addr, w_mem_addr_next;
  logic              r_instr_valid, w_instr_valid_next;
  logic [WORD_W-1:0] r_instr, w_instr_next;
  logic [WORD_W-1:0] r_instr_pc, w_instr_pc_next;
  logic              r_halted, w_halted_next;
  logic              r_fault, w_fault_next;
  logic [WORD_W-1:0] r_retired, w_retired_next;

  logic              w_wd_en, w_wd_clr, w_expire, w_consume;
  logic [WORD_W-1:0] w_pc_inc;

  // Only cycles with a live, unanswered request count toward the timeout.
  assign w_wd_en   = (r_state == ST_REQ) && r_mem_req && !mem_ack;
  assign w_wd_clr  = (r_state != ST_REQ);
  assign w_consume = r_instr_valid && !stall;
  assign w_pc_inc  = r_pc + WORD_W'(1);

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_mem_req_next     = r_mem_req;
    w_mem_addr_next    = r_mem_addr;
    w_instr_valid_next = r_instr_valid;
    w_instr_next       = r_instr;
    w_instr_pc_next    = r_instr_pc;
    w_halted_next      = r_halted;
    w_fault_next       = r_fault;
    w_retired_next     = r_retired;

    case (r_state)
      ST_REQ: begin
        if (r_mem_req && mem_ack) begin
          w_instr_next       = mem_rdata;
          w_instr_pc_next    = r_pc;
          w_instr_valid_next = 1'b1;
          w_mem_req_next     = 1'b0;
          w_state_next       = ST_ISSUE;
        end else if (w_expire) begin
          w_fault_next   = 1'b1;
          w_halted_next  = 1'b1;
          w_mem_req_next = 1'b0;
          w_state_next   = ST_HALT;
        end else begin
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = r_pc;
        end
      end

      ST_ISSUE: begin
        // The next request is launched straight from the consume cycle to keep 2-cycle throughput.
        if (w_consume) begin
          w_retired_next     = r_retired + WORD_W'(1);
          w_instr_valid_next = 1'b0;
          if (redirect) begin
            w_pc_next       = redirect_pc;
            w_mem_req_next  = 1'b1;
            w_mem_addr_next = redirect_pc;
            w_state_next    = ST_REQ;
          end else if (r_instr_pc == last_pc) begin
            w_halted_next = 1'b1;
            w_state_next  = ST_HALT;
          end else begin
            w_pc_next       = w_pc_inc;
            w_mem_req_next  = 1'b1;
            w_mem_addr_next = w_pc_inc;
            w_state_next    = ST_REQ;
          end
        end
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_retired     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_mem_req     <= w_mem_req_next;
      r_mem_addr    <= w_mem_addr_next;
      r_instr_valid <= w_instr_valid_next;
      r_instr       <= w_instr_next;
      r_instr_pc    <= w_instr_pc_next;
      r_halted      <= w_halted_next;
      r_fault       <= w_fault_next;
      r_retired     <= w_retired_next;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign retired     = r_retired;

endmodule
